// File: rtl/muldiv_sequencer_if.sv
// Issue/result bundle between CPU control and the multiply/divide unit.
// master: drives start/functcode/operands, observes busy/done/HI/LO.
// slave:  the multiply/divide unit itself.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       functcode;
  logic [WIDTH-1:0] rs_content;
  logic [WIDTH-1:0] rt_content;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, functcode, rs_content, rt_content,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, functcode, rs_content, rt_content,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO registers.
// Latency: MULT/MULTU/DIV/DIVU 35 cycles start-edge to done; MTHI/MTLO 1 cycle.
// Backpressure: busy high during PREP/RUN/FIXUP; any start seen while busy is dropped.
// Ports: clk, reset_n (sync, active-low); bus = start/functcode/rs/rt in,
//        busy/done/HI/LO out.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  muldiv_sequencer_if.slave    bus
);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  localparam logic [4:0] CNT_LAST = 5'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIXUP} state_t;

  state_t state, state_nxt;
  logic   busy_c;

  // Operation descriptor latched at issue
  logic             op_div;
  logic             op_signed;
  logic             div_zero;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH-1:0] b_raw;

  // Working registers: {acc_hi, acc_lo} is the product during multiply;
  // acc_hi is the partial remainder and acc_lo the dividend/quotient shifter
  // during divide.
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             neg_lo;   // product sign or quotient sign
  logic             neg_hi;   // remainder sign (dividend sign)
  logic [4:0]       cnt;

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;

  logic is_md;
  logic accept_md;
  logic accept_mthi;
  logic accept_mtlo;

  assign is_md = (bus.functcode == F_MULT) || (bus.functcode == F_MULTU) ||
                 (bus.functcode == F_DIV)  || (bus.functcode == F_DIVU);
  assign accept_md   = (state == IDLE) && bus.start && is_md;
  assign accept_mthi = (state == IDLE) && bus.start && (bus.functcode == F_MTHI);
  assign accept_mtlo = (state == IDLE) && bus.start && (bus.functcode == F_MTLO);

  // Sign handling for PREP. Negating 0x80000000 yields 0x80000000, which is
  // exactly the unsigned magnitude we want.
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign sign_a = op_signed & a_raw[WIDTH-1];
  assign sign_b = op_signed & b_raw[WIDTH-1];
  assign mag_a  = sign_a ? ({WIDTH{1'b0}} - a_raw) : a_raw;
  assign mag_b  = sign_b ? ({WIDTH{1'b0}} - b_raw) : b_raw;

  // One shift-add multiply step, LSB of the multiplier first.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : {(WIDTH+1){1'b0}});

  // One restoring divide step. The partial remainder is always below the
  // divisor, so the difference fits in WIDTH bits whenever it is taken.
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  assign div_trial = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_trial >= {1'b0, b_mag};
  assign div_diff  = div_trial[WIDTH-1:0] - b_mag;

  // Final sign correction and divide-by-zero override.
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    prod_fix = neg_lo ? ({(2*WIDTH){1'b0}} - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo   = prod_fix[WIDTH-1:0];
    if (op_div) begin
      if (div_zero) begin
        fix_hi = a_raw;
        fix_lo = {WIDTH{1'b1}};
      end else begin
        fix_hi = neg_hi ? ({WIDTH{1'b0}} - acc_hi) : acc_hi;
        fix_lo = neg_lo ? ({WIDTH{1'b0}} - acc_lo) : acc_lo;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b1;
    unique case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (accept_md) state_nxt = PREP;
      end
      PREP:  state_nxt = RUN;
      RUN:   if (cnt == CNT_LAST) state_nxt = FIXUP;
      FIXUP: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_div    <= 1'b0;
      op_signed <= 1'b0;
      div_zero  <= 1'b0;
      a_raw     <= '0;
      b_raw     <= '0;
      b_mag     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      neg_lo    <= 1'b0;
      neg_hi    <= 1'b0;
      cnt       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept_md) begin
            op_div    <= (bus.functcode == F_DIV) || (bus.functcode == F_DIVU);
            op_signed <= (bus.functcode == F_MULT) || (bus.functcode == F_DIV);
            div_zero  <= (bus.rt_content == '0);
            a_raw     <= bus.rs_content;
            b_raw     <= bus.rt_content;
          end
          if (accept_mthi) begin
            hi_q   <= bus.rs_content;
            done_q <= 1'b1;
          end
          if (accept_mtlo) begin
            lo_q   <= bus.rs_content;
            done_q <= 1'b1;
          end
        end
        PREP: begin
          acc_hi <= '0;
          acc_lo <= mag_a;
          b_mag  <= mag_b;
          neg_lo <= sign_a ^ sign_b;
          neg_hi <= sign_a;
          cnt    <= '0;
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (op_div) begin
            acc_hi <= div_ge ? div_diff : div_trial[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIXUP: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule
